// File: rtl/opcode_handshake_ctrl_if.sv
// opcode_handshake_ctrl_if
//   Bundles the command, downstream req/ack, data valid/ready and status
//   signals of opcode_handshake_ctrl.
//
//   modport master : the controller itself (drives cmd_ready, opcode, state,
//                    req, valid, out_data, error).
//   modport slave  : the surrounding agents (command source, downstream
//                    acknowledger, data consumer, property checker).
//
//   Signals
//     cmd_valid   command present
//     cmd_ready   controller can accept a command
//     cmd_opcode  3-bit command opcode
//     cmd_data    DATA_W command payload
//     opcode      latched opcode of the current/last command
//     state       FSM state encoding
//     req / ack   downstream request / acknowledge
//     valid/ready data valid / consumer ready
//     out_data    latched payload
//     error       sticky ack-timeout error
interface opcode_handshake_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_opcode;
    logic [DATA_W-1:0] cmd_data;
    logic [2:0]        opcode;
    logic [1:0]        state;
    logic              req;
    logic              ack;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] out_data;
    logic              error;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_data, ack, ready,
        output cmd_ready, opcode, state, req, valid, out_data, error
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_data, ack, ready,
        input  cmd_ready, opcode, state, req, valid, out_data, error
    );
endinterface

// File: rtl/opcode_handshake_ctrl.sv
// opcode_handshake_ctrl
//   Accepts one 3-bit opcode command at a time, runs a req/ack handshake with
//   a downstream agent and, for data opcodes, a valid/ready transfer of the
//   latched payload. An ack that fails to arrive within TIMEOUT req cycles
//   parks the controller in ERR with a sticky error until opcode 111 is
//   accepted.
//
//   Parameters
//     DATA_W   payload width (must match the interface DATA_W)
//     TIMEOUT  max req cycles without ack before error, must be >= 1
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    opcode_handshake_ctrl_if.master (command, req/ack,
//            valid/ready, opcode/state/out_data/error)
//
//   Optional build macro
//     OPCODE_HS_SVA_EN  compiles embedded concurrent assertions on the
//                       outputs; without it the logic is unchanged.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a command, cmd_ready=1
//   REQ   | req=1, waiting for ack, timeout counter running
//   XFER  | valid/ready transfer of out_data (optional 1-cycle gap)
//   ERR   | ack timed out, error=1, only opcode 111 leaves
module opcode_handshake_ctrl #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    opcode_handshake_ctrl_if.master bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        XFER = 2'b10,
        ERR  = 2'b11
    } state_t;

    state_t            st;
    logic [CNT_W-1:0]  cnt;
    logic              gap;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic              req_q;
    logic              valid_q;
    logic              error_q;
    logic              accept;

    assign bus.cmd_ready = (st == IDLE) || (st == ERR);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign bus.state    = st;
    assign bus.opcode   = op_q;
    assign bus.out_data = data_q;
    assign bus.req      = req_q;
    assign bus.valid    = valid_q;
    assign bus.error    = error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            cnt     <= '0;
            gap     <= 1'b0;
            op_q    <= 3'b000;
            data_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (accept) begin
                        // Every accepted command is latched, even opcodes
                        // that do nothing further.
                        op_q   <= bus.cmd_opcode;
                        data_q <= bus.cmd_data;
                        if (bus.cmd_opcode == 3'b000 ||
                            bus.cmd_opcode == 3'b001 ||
                            bus.cmd_opcode == 3'b010) begin
                            st    <= REQ;
                            req_q <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                end

                REQ: begin
                    // ack is checked first so an ack on the threshold
                    // cycle still completes the handshake.
                    if (bus.ack) begin
                        req_q <= 1'b0;
                        cnt   <= '0;
                        case (op_q)
                            3'b001: begin
                                st      <= XFER;
                                valid_q <= 1'b1;
                            end
                            3'b010: begin
                                st  <= XFER;
                                gap <= 1'b1;
                            end
                            default: st <= IDLE;
                        endcase
                    end else if (cnt == CNT_LAST) begin
                        st      <= ERR;
                        req_q   <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                XFER: begin
                    // The gap cycle keeps valid low one extra cycle; ready
                    // seen during it has no effect.
                    if (gap) begin
                        gap     <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (valid_q && bus.ready) begin
                        valid_q <= 1'b0;
                        st      <= IDLE;
                    end
                end

                ERR: begin
                    if (accept && bus.cmd_opcode == 3'b111) begin
                        error_q <= 1'b0;
                        st      <= IDLE;
                    end
                end

                default: st <= IDLE;
            endcase
        end
    end

`ifdef OPCODE_HS_SVA_EN
    // Opcode 001 does not promise ready will ever come, only that a stalled
    // beat is held.
    property p_op001_hold;
        @(posedge clk) disable iff (!rst_n)
            (bus.opcode == 3'b001 && bus.valid && !bus.ready)
                |=> (bus.valid && $stable(bus.out_data));
    endproperty

    property p_req_hold;
        @(posedge clk) disable iff (!rst_n)
            (bus.req && !bus.ack) |=> (bus.req || bus.error);
    endproperty

    property p_error_state;
        @(posedge clk) disable iff (!rst_n)
            bus.error |-> (bus.state == 2'b11);
    endproperty

    property p_req_state;
        @(posedge clk) disable iff (!rst_n)
            (bus.state == 2'b01) |-> bus.req;
    endproperty

    a_op001_hold:  assert property (p_op001_hold);
    a_req_hold:    assert property (p_req_hold);
    a_error_state: assert property (p_error_state);
    a_req_state:   assert property (p_req_state);
`endif

endmodule

// File: tb/tb_opcode_handshake_ctrl.sv
module tb_opcode_handshake_ctrl;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 10;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] data;
    } xfer_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    xfer_t sb[$];

    opcode_handshake_ctrl_if #(.DATA_W(DATA_W)) bus ();

    opcode_handshake_ctrl #(
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks in the main
    // flow happen at the same point, after the DUT has updated.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [DATA_W-1:0] d,
                            input bit push);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_data   = d;
        if (push) sb.push_back({op, d});
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    // Scoreboard consumer: every completed valid/ready beat must match the
    // oldest outstanding data command.
    always @(negedge clk) begin
        if (rst_n && bus.valid && bus.ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_beat", 32'd1, 32'd0);
            end else begin
                xfer_t e;
                e = sb.pop_front();
                check_eq("beat_data", 32'(bus.out_data), 32'(e.data));
                check_eq("beat_opcode", 32'(bus.opcode), 32'(e.op));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 3'b001;
        bus.cmd_data   = 8'h3C;
        bus.ack        = 1'b0;
        bus.ready      = 1'b0;

        // Reset holds everything idle even with a command presented.
        repeat (3) cyc();
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_state", 32'(bus.state), 32'd0);
        check_eq("rst_req", 32'(bus.req), 32'd0);
        check_eq("rst_valid", 32'(bus.valid), 32'd0);
        check_eq("rst_error", 32'(bus.error), 32'd0);
        check_eq("rst_opcode", 32'(bus.opcode), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);

        rst_n = 1'b1;
        sb.push_back({3'b001, 8'h3C});
        cyc();
        bus.cmd_valid = 1'b0;
        check_eq("post_rst_state", 32'(bus.state), 32'd1);
        check_eq("post_rst_req", 32'(bus.req), 32'd1);
        check_eq("post_rst_opcode", 32'(bus.opcode), 32'd1);
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        check_eq("post_rst_valid", 32'(bus.valid), 32'd1);
        bus.ready = 1'b1;
        cyc();
        bus.ready = 1'b0;
        check_eq("post_rst_idle", 32'(bus.state), 32'd0);

        // Opcode 000: ack on the 3rd REQ cycle, no data phase.
        send_cmd(3'b000, 8'h11, 1'b0);
        check_eq("op0_req_c1", 32'(bus.req), 32'd1);
        check_eq("op0_state_c1", 32'(bus.state), 32'd1);
        cyc();
        check_eq("op0_req_c2", 32'(bus.req), 32'd1);
        cyc();
        check_eq("op0_req_c3", 32'(bus.req), 32'd1);
        check_eq("op0_valid_c3", 32'(bus.valid), 32'd0);
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        check_eq("op0_req_done", 32'(bus.req), 32'd0);
        check_eq("op0_state_done", 32'(bus.state), 32'd0);
        check_eq("op0_valid_done", 32'(bus.valid), 32'd0);

        // Opcode with no effect: latched, stays idle.
        send_cmd(3'b101, 8'h99, 1'b0);
        check_eq("op5_state", 32'(bus.state), 32'd0);
        check_eq("op5_opcode", 32'(bus.opcode), 32'd5);
        check_eq("op5_data", 32'(bus.out_data), 32'h99);
        check_eq("op5_req", 32'(bus.req), 32'd0);

        // Opcode 001 with back-pressure.
        send_cmd(3'b001, 8'hA5, 1'b1);
        cyc();
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        check_eq("bp_state", 32'(bus.state), 32'd2);
        check_eq("bp_valid_c1", 32'(bus.valid), 32'd1);
        check_eq("bp_data_c1", 32'(bus.out_data), 32'hA5);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("bp_valid_hold", 32'(bus.valid), 32'd1);
            check_eq("bp_data_hold", 32'(bus.out_data), 32'hA5);
        end
        bus.ready = 1'b1;
        cyc();
        bus.ready = 1'b0;
        check_eq("bp_idle", 32'(bus.state), 32'd0);
        check_eq("bp_valid_done", 32'(bus.valid), 32'd0);

        // Opcode 010: gap cycle, ready during the gap is ignored.
        send_cmd(3'b010, 8'h5A, 1'b1);
        bus.ack   = 1'b1;
        bus.ready = 1'b1;
        cyc();
        bus.ack = 1'b0;
        check_eq("gap_state", 32'(bus.state), 32'd2);
        check_eq("gap_valid", 32'(bus.valid), 32'd0);
        cyc();
        check_eq("gap_state_c2", 32'(bus.state), 32'd2);
        check_eq("gap_valid_c2", 32'(bus.valid), 32'd1);
        cyc();
        bus.ready = 1'b0;
        check_eq("gap_idle", 32'(bus.state), 32'd0);

        // Timeout: req high exactly TIMEOUT cycles, then ERR.
        send_cmd(3'b001, 8'h77, 1'b0);
        n = 0;
        for (int i = 0; i < 2 * TIMEOUT && bus.req; i++) begin
            n++;
            cyc();
        end
        check_eq("to_req_cycles", 32'(n), 32'(TIMEOUT));
        check_eq("to_state", 32'(bus.state), 32'd3);
        check_eq("to_error", 32'(bus.error), 32'd1);
        check_eq("to_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        send_cmd(3'b000, 8'h00, 1'b0);
        check_eq("err_ign_state", 32'(bus.state), 32'd3);
        check_eq("err_ign_error", 32'(bus.error), 32'd1);
        check_eq("err_ign_req", 32'(bus.req), 32'd0);
        send_cmd(3'b111, 8'h00, 1'b0);
        check_eq("err_clr_error", 32'(bus.error), 32'd0);
        check_eq("err_clr_state", 32'(bus.state), 32'd0);

        // Ack on the last allowed REQ cycle wins over the timeout.
        send_cmd(3'b001, 8'hC3, 1'b1);
        repeat (TIMEOUT - 1) cyc();
        check_eq("bnd_req_last", 32'(bus.req), 32'd1);
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        check_eq("bnd_state", 32'(bus.state), 32'd2);
        check_eq("bnd_error", 32'(bus.error), 32'd0);
        check_eq("bnd_valid", 32'(bus.valid), 32'd1);

        // Asynchronous reset mid-transfer drops valid without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus.valid), 32'd0);
        check_eq("arst_state", 32'(bus.state), 32'd0);
        check_eq("arst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("arst_sb_pending", 32'(sb.size()), 32'd1);
        sb.delete();
        cyc();
        rst_n = 1'b1;
        cyc();
        check_eq("arst_req_after", 32'(bus.req), 32'd0);
        check_eq("arst_valid_after", 32'(bus.valid), 32'd0);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/opcode_handshake_ctrl.md
Name: opcode_handshake_ctrl

Overview:
Command-driven handshake controller that produces the opcode, state, req/ack, valid/ready and error signals checked by the team's case-selected SVA properties.
- Accepts one 3-bit opcode command at a time.
- Runs a req/ack handshake with a downstream agent, then optionally a valid/ready data transfer.
- Flags an ack timeout as a sticky error.
- Sits directly upstream of the property checker; the checker's inputs bind to this block's outputs.

Parameters:
- DATA_W, 8, width of command payload and out_data.
- TIMEOUT, 10, max cycles req may stay high without ack before error (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_opcode  input  3  command opcode.
- cmd_data  input  DATA_W  command payload.
- opcode  output  3  latched opcode of the current/last command.
- state  output  2  FSM state encoding.
- req  output  1  request to downstream.
- ack  input  1  downstream acknowledge.
- valid  output  1  data valid.
- ready  input  1  data consumer ready.
- out_data  output  DATA_W  latched payload.
- error  output  1  sticky timeout error.

Behaviour:
- Reset (async assert, sync release on clk): state=IDLE, opcode=0, req=0, valid=0, out_data=0, error=0, timeout counter=0, gap flag=0. Reset mid-handshake aborts immediately; no further req or valid is driven.
- State encoding: IDLE=2'b00, REQ=2'b01, XFER=2'b10, ERR=2'b11. All outputs are registered or decoded from registered state.
- cmd_ready=1 in IDLE and ERR, 0 otherwise. A command is accepted when cmd_valid && cmd_ready.
- IDLE, on accept: latch opcode and out_data.
  - Opcodes 000, 001, 010 -> REQ next cycle.
  - Opcodes 011..111 -> accepted, latched, no effect; stay IDLE.
- REQ: req=1.
  - Counter is cleared on entry and increments each REQ cycle with ack=0.
  - ack=1 with opcode 000 -> IDLE.
  - ack=1 with opcode 001 -> XFER; valid=1 in the first XFER cycle.
  - ack=1 with opcode 010 -> XFER with gap flag set. First XFER cycle has valid=0; valid=1 from the second XFER cycle (guarantees req |=> ##1 valid).
  - ack=0 when counter == TIMEOUT-1 -> ERR, so req is high for exactly TIMEOUT cycles.
  - ack arriving in the same cycle as the timeout threshold: ack wins, no error.
- XFER: out_data is held stable while valid=1 && ready=0. valid && ready -> IDLE next cycle. ready=1 during the gap cycle is ignored.
- ERR: error=1 (registered, set on entry). req=0, valid=0.
  - Accepted opcode 111 -> clear error, go to IDLE.
  - Any other accepted opcode is discarded; stay ERR.
- Counter width is $clog2(TIMEOUT+1) and never wraps (saturates at threshold).
- ack outside REQ and ready outside XFER are ignored.

Optional Feature:
- Macro: OPCODE_HS_SVA_EN.
- When defined, the module compiles embedded concurrent assertions clocked on posedge clk and disabled iff !rst_n:
  - case(opcode) property: 001 -> valid |-> ##[0:$] ready is not asserted, but valid && !ready |=> valid && $stable(out_data).
  - req && !ack |=> req unless error.
  - error |-> state==2'b11.
  - state==2'b01 |-> req.
- When not defined, there are no assertions and the RTL is identical.

Test Plan:
- Reset check: hold rst_n=0 and toggle clk with cmd_valid=1, opcode=001 -> cmd_ready=1, state=00, req/valid/error=0; after release, command accepted on first edge.
- Opcode 000: cmd 000 -> req=1 next cycle; ack on 3rd REQ cycle -> req=0, state=00 next cycle; valid never asserted.
- Opcode 001 with back-pressure: data=8'hA5, ack after 1 cycle, ready low for 4 cycles -> valid=1, out_data=8'hA5 stable for 5 cycles, IDLE after handshake.
- Opcode 010 gap: ack=1 in first REQ cycle -> next cycle state=10, valid=0; following cycle valid=1.
- Timeout: TIMEOUT=10, opcode 001, ack held 0 -> req high exactly 10 cycles, then state=11, error=1. Cmd 000 in ERR is ignored; cmd 111 -> error=0, state=00.
- Boundary: ack asserted in the 10th REQ cycle (TIMEOUT=10) -> no error, goes to XFER. Async rst_n pulse mid-XFER -> valid drops immediately.
